pipelined_multiplier_array: RTL and testbench

PIPELINED_MULTIPLIER_ARRAY -- requirements
Module: pipelined_multiplier_array

---
 rtl/gemm_pkg.sv | 22 ++
 rtl/pipelined_multiplier_lane.sv | 127 ++++++++++++
 rtl/pipelined_multiplier_array.sv | 99 +++++++++
 tb/tb_pipelined_multiplier_array.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and constants for the pipelined multiplier array.
package gemm_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'd0,
    MAC  = 2'd1,
    LOAD = 2'd2
  } op_e;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 8;

  // Map the raw two-bit op field onto the enum; the reserved code behaves as MUL.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return MAC;
      2'd2:    return LOAD;
      default: return MUL;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_multiplier_lane.sv
// One multiplier lane: full-width product, product pipeline, output
// conversion (truncate or clamp) and the lane accumulator in the final stage.
module pipelined_multiplier_lane
  import gemm_pkg::*;
#(
  parameter int unsigned INPUT_DATA_WIDTH  = 32,
  parameter int unsigned OUTPUT_DATA_WIDTH = 32,
  parameter int unsigned LATENCY           = 3,
  parameter int unsigned SIGNED            = 0,
  parameter int unsigned SATURATE          = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         advance,
  input  logic [INPUT_DATA_WIDTH-1:0]  a,
  input  logic [INPUT_DATA_WIDTH-1:0]  b,
  input  logic                         final_en,
  input  op_e                          final_op,
  output logic [OUTPUT_DATA_WIDTH-1:0] result
);

  localparam int unsigned IW = INPUT_DATA_WIDTH;
  localparam int unsigned OW = OUTPUT_DATA_WIDTH;
  localparam int unsigned PW = 2 * IW;
  // Working width: holds any product or sum with headroom for sign and carry.
  localparam int unsigned EW = ((PW > OW) ? PW : OW) + 2;

  localparam logic signed [EW-1:0] SMAX = (EW'(1) << (OW - 1)) - EW'(1);
  localparam logic signed [EW-1:0] SMIN = -(EW'(1) << (OW - 1));
  localparam logic signed [EW-1:0] UMAX = (EW'(1) << OW) - EW'(1);

  logic [PW-1:0]          a_ext;
  logic [PW-1:0]          b_ext;
  logic [PW-1:0]          product;
  logic [PW-1:0]          prod_final;
  logic [OW-1:0]          acc;
  logic signed [EW-1:0]   prod_wide;
  logic signed [EW-1:0]   sum_wide;
  logic [OW-1:0]          prod_conv;
  logic [OW-1:0]          mac_value;

  function automatic logic signed [EW-1:0] widen_prod(input logic [PW-1:0] v);
    if (SIGNED != 0) return {{(EW - PW){v[PW-1]}}, v};
    return {{(EW - PW){1'b0}}, v};
  endfunction

  function automatic logic signed [EW-1:0] widen_out(input logic [OW-1:0] v);
    if (SIGNED != 0) return {{(EW - OW){v[OW-1]}}, v};
    return {{(EW - OW){1'b0}}, v};
  endfunction

  // Bring a wide value into the output range: keep low bits, or clamp.
  function automatic logic [OW-1:0] fit(input logic signed [EW-1:0] v);
    logic [OW-1:0] r;
    r = v[OW-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if (v > SMAX)      r = SMAX[OW-1:0];
        else if (v < SMIN) r = SMIN[OW-1:0];
      end else begin
        if (v > UMAX)      r = '1;
      end
    end
    return r;
  endfunction

  // Full-width product; low 2*IW bits of the extended operands' product are exact.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{IW{a[IW-1]}}, a};
      b_ext = {{IW{b[IW-1]}}, b};
    end else begin
      a_ext = {{IW{1'b0}}, a};
      b_ext = {{IW{1'b0}}, b};
    end
    product = a_ext * b_ext;
  end

  if (LATENCY > 1) begin : g_prod_pipe
    logic [PW-1:0] prod_q [LATENCY-1];

    // Move products one stage toward the output whenever the chain advances.
    always_ff @(posedge clk) begin
      if (advance) begin
        prod_q[0] <= product;
        for (int unsigned k = 1; k < LATENCY - 1; k++) begin
          prod_q[k] <= prod_q[k-1];
        end
      end
    end

    assign prod_final = prod_q[LATENCY-2];
  end else begin : g_prod_direct
    assign prod_final = product;
  end

  // Conversion and accumulate arithmetic for the beat entering the final stage.
  always_comb begin
    prod_wide = widen_prod(prod_final);
    prod_conv = fit(prod_wide);
    sum_wide  = widen_out(acc) + widen_out(prod_conv);
    mac_value = fit(sum_wide);
  end

  // Final stage: the result and accumulator update together so MACs chain back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      acc    <= '0;
    end else if (final_en) begin
      case (final_op)
        LOAD: begin
          result <= prod_conv;
          acc    <= prod_conv;
        end
        MAC: begin
          result <= mac_value;
          acc    <= mac_value;
        end
        default: begin
          result <= prod_conv;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_multiplier_array.sv
// NUM parallel multiplier lanes sharing one valid/op pipeline with
// ready/valid handshakes on both sides. The whole chain stalls as one
// unit, so bubbles are kept and stalled beats are never dropped or repeated.
module pipelined_multiplier_array
  import gemm_pkg::*;
#(
  parameter int unsigned INPUT_DATA_WIDTH  = 32,
  parameter int unsigned OUTPUT_DATA_WIDTH = 32,
  parameter int unsigned NUM               = 4,
  parameter int unsigned LATENCY           = 3,
  parameter int unsigned SIGNED            = 0,
  parameter int unsigned SATURATE          = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [2*NUM-1:0][INPUT_DATA_WIDTH-1:0]  data_in,
  input  logic [1:0]                              in_op,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [NUM-1:0][OUTPUT_DATA_WIDTH-1:0]   data_out,
  output logic                                    out_valid,
  input  logic                                    out_ready
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("pipelined_multiplier_array: LATENCY must lie in %0d..%0d", LATENCY_MIN, LATENCY_MAX);
  end

  logic [LATENCY-1:0] stage_valid;
  logic               advance;
  logic               enter_valid;
  logic               final_en;
  op_e                in_op_dec;
  op_e                enter_op;

  assign advance   = !stage_valid[LATENCY-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = stage_valid[LATENCY-1];
  assign in_op_dec = decode_op(in_op);
  assign final_en  = advance && enter_valid;

  if (LATENCY > 1) begin : g_ctrl_pipe
    op_e op_q [LATENCY-1];

    // Shift valid bits one stage per advance; empty slots travel as bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_valid <= '0;
      end else if (advance) begin
        stage_valid <= {stage_valid[LATENCY-2:0], in_valid};
      end
    end

    // Carry each beat's op alongside it so the final stage sees the matching op.
    always_ff @(posedge clk) begin
      if (advance) begin
        op_q[0] <= in_op_dec;
        for (int unsigned k = 1; k < LATENCY - 1; k++) begin
          op_q[k] <= op_q[k-1];
        end
      end
    end

    assign enter_valid = stage_valid[LATENCY-2];
    assign enter_op    = op_q[LATENCY-2];
  end else begin : g_ctrl_direct
    // Single stage: an accepted beat goes straight into the output register.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_valid <= '0;
      end else if (advance) begin
        stage_valid <= in_valid;
      end
    end

    assign enter_valid = in_valid;
    assign enter_op    = in_op_dec;
  end

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    pipelined_multiplier_lane #(
      .INPUT_DATA_WIDTH (INPUT_DATA_WIDTH),
      .OUTPUT_DATA_WIDTH(OUTPUT_DATA_WIDTH),
      .LATENCY          (LATENCY),
      .SIGNED           (SIGNED),
      .SATURATE         (SATURATE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance),
      .a        (data_in[i]),
      .b        (data_in[i+NUM]),
      .final_en (final_en),
      .final_op (enter_op),
      .result   (data_out[i])
    );
  end

endmodule

// File: tb/tb_pipelined_multiplier_array.sv
// Bench for pipelined_multiplier_array: three configurations
// (default unsigned/wrap L=3, signed/saturate L=3, unsigned/wrap L=1)
// checked against an arithmetic reference model and a per-DUT scoreboard.
module tb_pipelined_multiplier_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [7:0][31:0]  din [3];
  logic [1:0]        op [3];
  logic [2:0]        in_valid;
  logic [2:0]        in_ready;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [3:0][31:0]  dout [3];

  pipelined_multiplier_array #(
    .INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(32), .NUM(4),
    .LATENCY(3), .SIGNED(0), .SATURATE(0)
  ) dut (
    .clk(clk), .rst(rst), .data_in(din[0]), .in_op(op[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .data_out(dout[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  pipelined_multiplier_array #(
    .INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(32), .NUM(4),
    .LATENCY(3), .SIGNED(1), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .data_in(din[1]), .in_op(op[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .data_out(dout[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  pipelined_multiplier_array #(
    .INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(32), .NUM(4),
    .LATENCY(1), .SIGNED(0), .SATURATE(0)
  ) dut_l1 (
    .clk(clk), .rst(rst), .data_in(din[2]), .in_op(op[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .data_out(dout[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2])
  );

  typedef struct {
    logic [3:0][31:0] v;
    int               cyc;
  } exp_t;

  exp_t             sb [3][$];
  logic [31:0]      acc [3][4];
  bit               lat_chk [3];
  int               bp_mode [3];
  bit               hold_v [3];
  logic [3:0][31:0] held [3];
  int               cyc = 0;
  int               n_tests = 0;
  int               n_fail = 0;

  function automatic bit cfg_signed(input int d); return d == 1; endfunction
  function automatic bit cfg_sat(input int d);    return d == 1; endfunction
  function automatic int cfg_lat(input int d);    return (d == 2) ? 1 : 3; endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: exact integer value, then wrap to 32 bits or clamp.
  function automatic logic signed [127:0] as_int(input logic [31:0] x, input bit sg);
    logic signed [127:0] r;
    if (sg && x[31]) r = $signed({96'd0, x}) - (128'sd1 <<< 32);
    else             r = $signed({96'd0, x});
    return r;
  endfunction

  function automatic logic [31:0] to_out(input logic signed [127:0] v, input bit sg, input bit st);
    if (st && sg) begin
      if (v > 128'sd2147483647)  return 32'h7FFF_FFFF;
      if (v < -128'sd2147483648) return 32'h8000_0000;
    end else if (st) begin
      if (v > 128'sd4294967295)  return 32'hFFFF_FFFF;
      if (v < 128'sd0)           return 32'h0000_0000;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0][31:0] model_beat(input int d, input logic [1:0] opc,
                                                  input logic [7:0][31:0] x);
    logic [3:0][31:0] r;
    logic [31:0]      p;
    bit sg, st;
    sg = cfg_signed(d);
    st = cfg_sat(d);
    for (int i = 0; i < 4; i++) begin
      p = to_out(as_int(x[i], sg) * as_int(x[i+4], sg), sg, st);
      if (opc == 2'd1) begin
        r[i] = to_out(as_int(acc[d][i], sg) + as_int(p, sg), sg, st);
        acc[d][i] = r[i];
      end else if (opc == 2'd2) begin
        r[i] = p;
        acc[d][i] = p;
      end else begin
        r[i] = p;
      end
    end
    return r;
  endfunction

  // Scoreboard: observe handshakes mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        sb[d].delete();
        for (int i = 0; i < 4; i++) acc[d][i] = '0;
        hold_v[d] = 1'b0;
      end else begin
        if (hold_v[d]) begin
          check_eq($sformatf("hold_valid%0d", d), out_valid[d], 1'b1);
          check_eq($sformatf("hold_data%0d", d), dout[d], held[d]);
        end
        if (out_valid[d] && out_ready[d]) begin
          if (sb[d].size() == 0) begin
            check_eq($sformatf("extra_out%0d", d), out_valid[d], 1'b0);
          end else begin
            e = sb[d].pop_front();
            for (int i = 0; i < 4; i++)
              check_eq($sformatf("dut%0d_lane%0d", d, i), dout[d][i], e.v[i]);
            if (lat_chk[d])
              check_eq($sformatf("latency%0d", d), cyc - e.cyc, cfg_lat(d));
          end
        end
        hold_v[d] = out_valid[d] && !out_ready[d];
        held[d]   = dout[d];
        if (in_valid[d] && in_ready[d]) begin
          e.v   = model_beat(d, op[d], din[d]);
          e.cyc = cyc;
          sb[d].push_back(e);
        end
      end
    end
  end

  // Downstream ready: always on, 1,0,0,1 pattern, or random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        case (bp_mode[d])
          1:       out_ready[d] = (cyc % 4 == 0) || (cyc % 4 == 3);
          2:       out_ready[d] = 1'($urandom_range(0, 1));
          default: out_ready[d] = 1'b1;
        endcase
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0][31:0] spl(input logic [31:0] x);
    return {x, x, x, x};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0][31:0] rnd_vec();
    logic [3:0][31:0] v;
    for (int i = 0; i < 4; i++) v[i] = rnd32();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT takes it.
  task automatic send(input int d, input logic [1:0] opc,
                      input logic [3:0][31:0] a, input logic [3:0][31:0] b);
    bit taken;
    taken = 1'b0;
    din[d]      = {b, a};
    op[d]       = opc;
    in_valid[d] = 1'b1;
    for (int t = 0; t < 200 && !taken; t++) begin
      @(negedge clk);
      taken = in_ready[d];
      tick();
    end
    if (!taken) check_eq($sformatf("send_timeout%0d", d), taken, 1'b1);
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while ((sb[d].size() != 0 || out_valid[d]) && t < 400) begin
      tick();
      t++;
    end
    check_eq($sformatf("drain%0d", d), sb[d].size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    for (int d = 0; d < 3; d++) begin
      din[d]     = '0;
      op[d]      = '0;
      lat_chk[d] = 1'b1;
      bp_mode[d] = 0;
    end
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_out_valid%0d", d), out_valid[d], 1'b0);
      check_eq($sformatf("rst_in_ready%0d", d), in_ready[d], 1'b1);
      check_eq($sformatf("rst_data_out%0d", d), dout[d], '0);
    end
    tick();

    // Unsigned truncation, 3-cycle latency.
    send(0, 2'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7}, {32'd2, 32'd2, 32'd2, 32'd6});
    drain(0);
    check_eq("trunc_lane0", dout[0][0], 32'd42);
    check_eq("trunc_lane3", dout[0][3], 32'hFFFF_FFFE);

    // Signed saturating configuration.
    send(1, 2'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7}, {32'd2, 32'd2, 32'd2, 32'd6});
    drain(1);
    check_eq("sat_neg2", dout[1][2], 32'hFFFF_FFFE);
    send(1, 2'd0, spl(32'h7FFF_FFFF), spl(32'd2));
    drain(1);
    check_eq("sat_clamp", dout[1][1], 32'h7FFF_FFFF);

    // Accumulate chain, back-to-back; trailing MAC 0x0 exposes the accumulator.
    send(0, 2'd2, spl(32'd3), spl(32'd4));
    send(0, 2'd1, spl(32'd2), spl(32'd5));
    send(0, 2'd1, spl(32'd1), spl(32'd1));
    send(0, 2'd0, spl(32'd9), spl(32'd9));
    send(0, 2'd1, spl(32'd0), spl(32'd0));
    drain(0);
    check_eq("acc_after_mul", dout[0][1], 32'd23);

    // Back-pressure with ready pattern 1,0,0,1.
    lat_chk[0] = 1'b0;
    bp_mode[0] = 1;
    for (int n = 0; n < 10; n++) send(0, 2'd0, rnd_vec(), rnd_vec());
    drain(0);
    bp_mode[0] = 0;
    tick();
    lat_chk[0] = 1'b1;

    // Reset with two beats in flight.
    send(0, 2'd0, spl(32'd5), spl(32'd5));
    send(0, 2'd2, spl(32'd6), spl(32'd6));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid[0], 1'b0);
    check_eq("midrst_data_out", dout[0], '0);
    tick();
    send(0, 2'd1, spl(32'd2), spl(32'd3));
    drain(0);
    check_eq("mac_after_rst", dout[0][0], 32'd6);

    // LATENCY=1 continuous stream.
    for (int n = 0; n < 20; n++) send(2, 2'($urandom_range(0, 3)), rnd_vec(), rnd_vec());
    drain(2);

    // Randomized traffic with random gaps and random downstream stalls.
    for (int d = 0; d < 3; d++) begin
      lat_chk[d] = 1'b0;
      bp_mode[d] = 2;
      for (int n = 0; n < 150; n++) begin
        send(d, 2'($urandom_range(0, 3)), rnd_vec(), rnd_vec());
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end
      drain(d);
      bp_mode[d] = 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
